qubit_gate_sequencer: RTL



---
 rtl/qubit_gate_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/qubit_gate_sequencer.sv
// Purpose : applies a stream of single-qubit gate opcodes to a held (alpha, beta) state.
// Latency : non-H ops 1 cycle each (1 op/cycle back-to-back), H 2 cycles; result valid the cycle after the last op.
// Backpr. : load_ready only in IDLE, op_ready only in RUN; the result holds in DONE until out_ready.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   load_valid/load_ready, in_*    initial state (Q2.14 complex amplitudes)
//   op_valid/op_ready, op_code,    gate stream: 0=I 1=X 2=Y 3=Z 4=H 5=S 6=Sdg 7=reserved
//   op_last                        marks the final op of a program
//   out_valid/out_ready, out_*     final state; out_* are the live state registers
//   busy, op_count, illegal_op     status: not idle, ops since load (saturating), reserved op seen
module qubit_gate_sequencer #(
   parameter int                DATA_W    = 16,
   parameter int                COUNT_W   = 8,
   parameter logic [DATA_W-1:0] INV_SQRT2 = 16'd11585
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [DATA_W-1:0]  in_alpha_re,
   input  logic [DATA_W-1:0]  in_alpha_im,
   input  logic [DATA_W-1:0]  in_beta_re,
   input  logic [DATA_W-1:0]  in_beta_im,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [2:0]         op_code,
   input  logic               op_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_alpha_re,
   output logic [DATA_W-1:0]  out_alpha_im,
   output logic [DATA_W-1:0]  out_beta_re,
   output logic [DATA_W-1:0]  out_beta_im,
   output logic               busy,
   output logic [COUNT_W-1:0] op_count,
   output logic               illegal_op
);

   typedef enum logic [1:0] {IDLE, RUN, H_MUL, DONE} state_t;

   localparam logic [2:0] OP_I   = 3'd0;
   localparam logic [2:0] OP_X   = 3'd1;
   localparam logic [2:0] OP_Y   = 3'd2;
   localparam logic [2:0] OP_Z   = 3'd3;
   localparam logic [2:0] OP_H   = 3'd4;
   localparam logic [2:0] OP_S   = 3'd5;
   localparam logic [2:0] OP_SDG = 3'd6;

   localparam int PW = 2*DATA_W + 1;  // 17x16 signed product width

   // rounding constant 2^(frac-1) and saturation bounds, all at product width
   localparam logic signed [PW-1:0] HALF = {{(DATA_W+3){1'b0}}, 1'b1, {(DATA_W-3){1'b0}}};
   localparam logic signed [PW-1:0] SMAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] SMIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

   state_t              state;
   logic signed [DATA_W:0] s0_re, s0_im, s1_re, s1_im;
   logic                h_last;

   // saturating negate: the most negative value has no positive twin
   function automatic logic [DATA_W-1:0] sneg(input logic [DATA_W-1:0] x);
      if (x == {1'b1, {(DATA_W-1){1'b0}}})
         return {1'b0, {(DATA_W-1){1'b1}}};
      return ~x + 1'b1;
   endfunction

   // sat((s * 1/sqrt2 + half) >>> frac), round-half-up in Q2.14
   function automatic logic [DATA_W-1:0] hmul(input logic signed [DATA_W:0] s);
      logic signed [PW-1:0] prod;
      logic signed [PW-1:0] rnd;
      prod = s * $signed(INV_SQRT2);
      rnd  = (prod + HALF) >>> (DATA_W-2);
      if (rnd > SMAX)
         return SMAX[DATA_W-1:0];
      if (rnd < SMIN)
         return SMIN[DATA_W-1:0];
      return rnd[DATA_W-1:0];
   endfunction

   // handshake readiness is a pure decode of the state register
   assign load_ready = (state == IDLE);
   assign op_ready   = (state == RUN);
   assign out_valid  = (state == DONE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         out_alpha_re <= '0;
         out_alpha_im <= '0;
         out_beta_re  <= '0;
         out_beta_im  <= '0;
         s0_re        <= '0;
         s0_im        <= '0;
         s1_re        <= '0;
         s1_im        <= '0;
         h_last       <= 1'b0;
         op_count     <= '0;
         illegal_op   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_valid) begin
                  out_alpha_re <= in_alpha_re;
                  out_alpha_im <= in_alpha_im;
                  out_beta_re  <= in_beta_re;
                  out_beta_im  <= in_beta_im;
                  op_count     <= '0;
                  illegal_op   <= 1'b0;
                  state        <= RUN;
               end
            end
            RUN: begin
               if (op_valid) begin
                  if (op_count != {COUNT_W{1'b1}})
                     op_count <= op_count + 1'b1;
                  case (op_code)
                     OP_I: ;
                     OP_X: begin
                        out_alpha_re <= out_beta_re;
                        out_alpha_im <= out_beta_im;
                        out_beta_re  <= out_alpha_re;
                        out_beta_im  <= out_alpha_im;
                     end
                     OP_Y: begin
                        out_alpha_re <= out_beta_im;
                        out_alpha_im <= sneg(out_beta_re);
                        out_beta_re  <= sneg(out_alpha_im);
                        out_beta_im  <= out_alpha_re;
                     end
                     OP_Z: begin
                        out_beta_re <= sneg(out_beta_re);
                        out_beta_im <= sneg(out_beta_im);
                     end
                     OP_H: begin
                        // 17-bit sums keep the full range; scaling happens next cycle
                        s0_re  <= {out_alpha_re[DATA_W-1], out_alpha_re} + {out_beta_re[DATA_W-1], out_beta_re};
                        s0_im  <= {out_alpha_im[DATA_W-1], out_alpha_im} + {out_beta_im[DATA_W-1], out_beta_im};
                        s1_re  <= {out_alpha_re[DATA_W-1], out_alpha_re} - {out_beta_re[DATA_W-1], out_beta_re};
                        s1_im  <= {out_alpha_im[DATA_W-1], out_alpha_im} - {out_beta_im[DATA_W-1], out_beta_im};
                        h_last <= op_last;
                     end
                     OP_S: begin
                        out_beta_re <= sneg(out_beta_im);
                        out_beta_im <= out_beta_re;
                     end
                     OP_SDG: begin
                        out_beta_re <= out_beta_im;
                        out_beta_im <= sneg(out_beta_re);
                     end
                     default: illegal_op <= 1'b1;  // reserved code acts as identity
                  endcase
                  if (op_code == OP_H)
                     state <= H_MUL;
                  else if (op_last)
                     state <= DONE;
               end
            end
            H_MUL: begin
               out_alpha_re <= hmul(s0_re);
               out_alpha_im <= hmul(s0_im);
               out_beta_re  <= hmul(s1_re);
               out_beta_im  <= hmul(s1_im);
               state        <= h_last ? DONE : RUN;
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
